cmp_crossing_detector: RTL and testbench

Sequential consumer of the 8-bit magnitude comparator's outputs: samples the one-hot `greater`/`equal`/`less` flags, debounces them, and tracks whether operand A is persistently above B. It emits single-cycle rising and falling crossing pulses and keeps a saturating event count. It sits directly downstream of the comparator, which compares a sampled value (A) against a threshold (B).

---
 rtl/cmp_crossing_detector.sv | 152 +++++++++++++++
 tb/tb_cmp_crossing_detector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_crossing_detector.sv
// Debounced "A above B" tracker fed by a one-hot magnitude comparator.
// Emits registered rise/fall pulses, a saturating event count and error flags.
module cmp_crossing_detector #(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             greater,
   input  logic             equal,
   input  logic             less,
   output logic             above,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] event_count,
   output logic             err_pulse,
   output logic             err_sticky
);

   typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;

   localparam logic [7:0] DEB = 8'(DEBOUNCE);

   state_t           state_q, state_d;
   logic [7:0]       run_q, run_d;
   logic             above_q, above_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;

   logic             is_hi, is_lo;
   logic [7:0]       run_inc;

   assign is_hi   = greater & ~equal & ~less;
   assign is_lo   = ~greater & (equal ^ less);
   assign run_inc = run_q + 8'd1;

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      err_d    = 1'b0;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      above_d  = above_q;

      if (in_valid) begin
         // Non-one-hot samples are flagged and otherwise ignored, so runs survive them.
         if (!is_hi && !is_lo) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
         end else begin
            case (state_q)
               LOW: begin
                  if (is_hi) begin
                     if (DEB == 8'd1) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                     end else begin
                        state_d = RISE_PEND;
                        run_d   = 8'd1;
                     end
                  end
               end
               RISE_PEND: begin
                  if (is_hi) begin
                     if (run_inc == DEB) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                        run_d   = 8'd0;
                     end else begin
                        run_d = run_inc;
                     end
                  end else begin
                     state_d = LOW;
                     run_d   = 8'd0;
                  end
               end
               HIGH: begin
                  if (is_lo) begin
                     if (DEB == 8'd1) begin
                        state_d = LOW;
                        fall_d  = 1'b1;
                     end else begin
                        state_d = FALL_PEND;
                        run_d   = 8'd1;
                     end
                  end
               end
               FALL_PEND: begin
                  if (is_lo) begin
                     if (run_inc == DEB) begin
                        state_d = LOW;
                        fall_d  = 1'b1;
                        run_d   = 8'd0;
                     end else begin
                        run_d = run_inc;
                     end
                  end else begin
                     state_d = HIGH;
                     run_d   = 8'd0;
                  end
               end
               default: begin
                  state_d = LOW;
                  run_d   = 8'd0;
               end
            endcase
         end
      end

      if ((rise_d || fall_d) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      above_d = (state_d == HIGH) || (state_d == FALL_PEND);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOW;
         run_q    <= 8'd0;
         above_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         above_q  <= above_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end

   assign above       = above_q;
   assign rise_pulse  = rise_q;
   assign fall_pulse  = fall_q;
   assign event_count = cnt_q;
   assign err_pulse   = err_q;
   assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_cmp_crossing_detector.sv
// Scoreboard bench: two detector configurations share one input stream and are
// checked cycle by cycle against a level/streak reference model.
module tb_cmp_crossing_detector;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic greater = 1'b0;
   logic equal = 1'b0;
   logic less = 1'b0;

   logic       a_above, a_rise, a_fall, a_err, a_sticky;
   logic [7:0] a_cnt;
   logic       b_above, b_rise, b_fall, b_err, b_sticky;
   logic [1:0] b_cnt;

   always #5 clk = ~clk;

   cmp_crossing_detector #(.DEBOUNCE(3), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .greater(greater), .equal(equal), .less(less),
      .above(a_above), .rise_pulse(a_rise), .fall_pulse(a_fall),
      .event_count(a_cnt), .err_pulse(a_err), .err_sticky(a_sticky)
   );

   cmp_crossing_detector #(.DEBOUNCE(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .greater(greater), .equal(equal), .less(less),
      .above(b_above), .rise_pulse(b_rise), .fall_pulse(b_fall),
      .event_count(b_cnt), .err_pulse(b_err), .err_sticky(b_sticky)
   );

   typedef struct {
      bit level;
      int streak;
      int cnt;
      bit sticky;
      bit rise;
      bit fall;
      bit err;
   } mdl_t;

   typedef struct {
      mdl_t a;
      mdl_t b;
   } exp_t;

   mdl_t ma, mb;
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Level changes once `deb` consecutive valid samples disagree with it.
   function automatic mdl_t mdl_next(mdl_t s, int deb, int cmax,
                                     bit r, bit v, bit g, bit e, bit l);
      mdl_t n;
      bit   hi;
      int   ones;
      n      = s;
      n.rise = 0;
      n.fall = 0;
      n.err  = 0;
      ones   = int'(g) + int'(e) + int'(l);
      hi     = g;
      if (r) begin
         n = '{default: 0};
      end else if (v) begin
         if (ones != 1) begin
            n.err    = 1;
            n.sticky = 1;
         end else if (hi != n.level) begin
            n.streak++;
            if (n.streak == deb) begin
               n.level  = hi;
               n.streak = 0;
               if (hi) n.rise = 1;
               else    n.fall = 1;
               if (n.cnt < cmax) n.cnt++;
            end
         end else begin
            n.streak = 0;
         end
      end
      return n;
   endfunction

   task automatic check(string name, int got, int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("[TB] FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // One clock of stimulus: drive, let the edge happen, then queue the expectation.
   task automatic applyStimulus(bit r, bit v, bit g, bit e, bit l);
      exp_t x;
      rst = r; in_valid = v; greater = g; equal = e; less = l;
      ma = mdl_next(ma, 3, 255, r, v, g, e, l);
      mb = mdl_next(mb, 1, 3, r, v, g, e, l);
      @(posedge clk);
      #1;
      x.a = ma;
      x.b = mb;
      sb_q.push_back(x);
   endtask

   task automatic hi_s();   applyStimulus(0, 1, 1, 0, 0); endtask
   task automatic lo_s();   applyStimulus(0, 1, 0, 0, 1); endtask
   task automatic eq_s();   applyStimulus(0, 1, 0, 1, 0); endtask
   task automatic bad_s();  applyStimulus(0, 1, 1, 0, 1); endtask
   task automatic idle_s(); applyStimulus(0, 0, 1, 0, 0); endtask
   task automatic rst_s();  applyStimulus(1, 1, 1, 0, 0); endtask

   task automatic checkOutput(exp_t x);
      check("a_above", int'(a_above), int'(x.a.level));
      check("a_rise", int'(a_rise), int'(x.a.rise));
      check("a_fall", int'(a_fall), int'(x.a.fall));
      check("a_count", int'(a_cnt), x.a.cnt);
      check("a_err", int'(a_err), int'(x.a.err));
      check("a_sticky", int'(a_sticky), int'(x.a.sticky));
      check("b_above", int'(b_above), int'(x.b.level));
      check("b_rise", int'(b_rise), int'(x.b.rise));
      check("b_fall", int'(b_fall), int'(x.b.fall));
      check("b_count", int'(b_cnt), x.b.cnt);
      check("b_err", int'(b_err), int'(x.b.err));
      check("b_sticky", int'(b_sticky), int'(x.b.sticky));
   endtask

   // Monitor: every registered output update is matched against the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            checkOutput(x);
         end
      end
   end

   initial begin
      int sel;
      ma = '{default: 0};
      mb = '{default: 0};

      rst_s(); rst_s();
      repeat (10) idle_s();

      hi_s(); hi_s(); hi_s();
      eq_s(); eq_s(); eq_s();
      hi_s(); hi_s(); lo_s(); hi_s(); hi_s(); hi_s();
      lo_s(); lo_s(); lo_s();

      rst_s();
      hi_s(); bad_s(); hi_s(); hi_s();
      idle_s(); idle_s();
      eq_s(); idle_s(); eq_s(); idle_s(); idle_s(); eq_s();

      rst_s();
      repeat (3) begin hi_s(); lo_s(); end
      hi_s(); rst_s(); idle_s();

      repeat (600) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 2) begin
            rst_s();
         end else if (sel < 22) begin
            idle_s();
         end else if (sel < 60) begin
            hi_s();
         end else if (sel < 72) begin
            eq_s();
         end else if (sel < 90) begin
            lo_s();
         end else begin
            applyStimulus(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)) | 1'(sel[0]));
         end
      end

      idle_s();
      @(negedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
